uart_param: RTL and testbench

Parametrised full-duplex UART successor: one TX and one RX engine on a single system clock, with internal bit timing instead of an external protocol clock. Adds configurable data width, parity mode and stop-bit count, mid-bit RX sampling with start-bit glitch rejection, and explicit parity/framing error reporting. Sits between the system-side byte interface and the serial line pins.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_param.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART: FSM state encodings,
// parity mode constants and the parity-bit function.
package uart_pkg;

    localparam int MAX_W = 9;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Callers zero-extend payloads to MAX_W; zero bits do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_W-1:0] data, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter. tick is high while the count is zero;
// the counter then reloads CLK_DIV-1 so ticks recur every CLK_DIV cycles.
module uart_bit_timer #(
    parameter int CLK_DIV = 16,
    parameter int W       = $clog2(CLK_DIV)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (load)
            cnt_d = load_val;
        else if (cnt_q == '0)
            cnt_d = RELOAD;
        else
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= RELOAD;
        else
            cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_param.sv
// Full-duplex UART with independent TX and RX engines on one clock.
// Define UART_RX_SYNC_EN to put a two-flop synchroniser on rx.
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_transmission,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rx,
    output logic              tx,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output tx_state_e         tx_state_dbg,
    output rx_state_e         rx_state_dbg
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] TX_LOAD   = TW'(CLK_DIV - 1);
    // The sample fires the edge after the count reaches zero, hence the -1.
    localparam logic [TW-1:0] RX_LOAD   = TW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [1:0]    PAR_MODE  = 2'(PARITY);
    localparam bit            PAR_EN    = (PARITY != 0);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q, rx_sync_d;
    assign rx_sync_d = {rx_sync_q[0], rx};
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rx_sync_q <= 2'b11;
        else
            rx_sync_q <= rx_sync_d;
    end
    assign rx_s = rx_sync_q[1];
`else
    assign rx_s = rx;
`endif

    // ---------------- TX engine ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic              tx_load, tx_tick;

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (tx_load),
        .load_val (TX_LOAD),
        .tick     (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_bit_d   = tx_bit_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (start_transmission) begin
                tx_shift_d = data_in;
                tx_par_d   = parity_bit(MAX_W'(data_in), PAR_MODE);
                tx_bit_d   = '0;
                tx_load    = 1'b1;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA: if (tx_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == LAST_DATA) begin
                    tx_bit_d   = '0;
                    tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
            TX_STOP: if (tx_tick) begin
                if (tx_bit_q == LAST_STOP)
                    tx_state_d = TX_IDLE;
                else
                    tx_bit_d = tx_bit_q + 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        case (tx_state_q)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift_q[0];
            TX_PARITY: tx = tx_par_q;
            default:   tx = 1'b1;
        endcase
    end

    assign busy         = (tx_state_q != TX_IDLE);
    assign tx_state_dbg = tx_state_q;

    // ---------------- RX engine ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_dout_q, rx_dout_d;
    logic              rx_par_q, rx_par_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic              rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d;
    logic              rx_load, rx_tick;

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (rx_load),
        .load_val (RX_LOAD),
        .tick     (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_dout_d  = rx_dout_q;
        rx_par_d   = rx_par_q;
        rx_bit_d   = rx_bit_q;
        rdy_d      = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        rx_load    = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_s) begin
                rx_load    = 1'b1;
                rx_state_d = RX_START;
            end
            RX_START: if (rx_tick) begin
                rx_bit_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
                if (rx_bit_q == LAST_DATA)
                    rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                else
                    rx_bit_d = rx_bit_q + 1'b1;
            end
            RX_PARITY: if (rx_tick) begin
                rx_par_d   = rx_s;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_tick) begin
                rx_dout_d = rx_shift_q;
                if (!rx_s) begin
                    ferr_d     = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                end else begin
                    if (PAR_EN && (rx_par_q != parity_bit(MAX_W'(rx_shift_q), PAR_MODE)))
                        perr_d = 1'b1;
                    else
                        rdy_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_dout_q  <= '0;
            rx_par_q   <= 1'b0;
            rx_bit_q   <= '0;
            rdy_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_dout_q  <= rx_dout_d;
            rx_par_q   <= rx_par_d;
            rx_bit_q   <= rx_bit_d;
            rdy_q      <= rdy_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_out     = rx_dout_q;
    assign data_ready   = rdy_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param with default parameters (8 data bits,
// 16 clocks per bit, even parity, one stop bit).
module tb_uart_param;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_transmission;
    logic [7:0] data_in;
    logic       rx;
    logic       tx, busy;
    logic [7:0] data_out;
    logic       data_ready, parity_err, frame_err;
    tx_state_e  tx_state_dbg;
    rx_state_e  rx_state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [0:0] exp_q[$];
    int n_rdy, n_perr, n_ferr, first_idx, last_idx;

    uart_param #(.DATA_W(8), .CLK_DIV(16), .PARITY(1), .STOP_BITS(1)) dut (
        .clk                (clk),
        .reset              (reset),
        .start_transmission (start_transmission),
        .data_in            (data_in),
        .rx                 (rx),
        .tx                 (tx),
        .busy               (busy),
        .data_out           (data_out),
        .data_ready         (data_ready),
        .parity_err         (parity_err),
        .frame_err          (frame_err),
        .tx_state_dbg       (tx_state_dbg),
        .rx_state_dbg       (rx_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends one frame from a negedge; checks tx at the first and last cycle of
    // each bit, optionally pulses start_transmission again at frame cycle retrig_at.
    task automatic run_tx(input logic [7:0] d, input int retrig_at);
        logic [10:0] frame;
        int          idle_bad;
        frame = {1'b1, ^d, d, 1'b0};
        for (int b = 0; b < 11; b++) exp_q.push_back(frame[b]);
        start_transmission = 1'b1;
        data_in            = d;
        @(negedge clk);
        start_transmission = 1'b0;
        for (int b = 0; b < 11; b++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            for (int c = 0; c < 16; c++) begin
                if (c == 0 || c == 15) begin
                    check_eq($sformatf("tx_bit%0d_c%0d", b, c), 32'(tx), 32'(e));
                    check_eq($sformatf("busy_bit%0d_c%0d", b, c), 32'(busy), 1);
                end
                if (b * 16 + c == retrig_at) begin
                    start_transmission = 1'b1;
                    data_in            = ~d;
                end else begin
                    start_transmission = 1'b0;
                end
                @(negedge clk);
            end
        end
        check_eq("busy_after_frame", 32'(busy), 0);
        check_eq("tx_after_frame", 32'(tx), 1);
        idle_bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
            @(negedge clk);
        end
        check_eq("tx_idle_window", 32'(idle_bad), 0);
    endtask

    // Drives rx = bits[i/bitlen] for nbits*bitlen cycles, then high for tail
    // cycles, counting result pulses and the cycle index they appear at.
    task automatic rx_run(input logic [21:0] bits, input int nbits, input int bitlen, input int tail);
        n_rdy = 0; n_perr = 0; n_ferr = 0; first_idx = -1; last_idx = -1;
        for (int i = 0; i < nbits * bitlen + tail; i++) begin
            if (data_ready || parity_err || frame_err) begin
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
            if (data_ready) n_rdy++;
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            rx = (i < nbits * bitlen) ? bits[i / bitlen] : 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        reset              = 1'b1;
        rx                 = 1'b1;
        start_transmission = 1'b0;
        data_in            = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_data_out", 32'(data_out), 0);
        check_eq("rst_pulses", 32'({data_ready, parity_err, frame_err}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // RX: well-formed 0x3C, even parity 0
        rx_run({11'h0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 16, 24);
        check_eq("rx3c_rdy", n_rdy, 1);
        check_eq("rx3c_perr", n_perr, 0);
        check_eq("rx3c_ferr", n_ferr, 0);
        check_eq("rx3c_pulse_cycle", first_idx, 169);
        check_eq("rx3c_data", 32'(data_out), 32'h3C);

        // RX: 0x01 with wrong parity bit 0
        rx_run({11'h0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 16, 24);
        check_eq("rx01_perr", n_perr, 1);
        check_eq("rx01_rdy", n_rdy, 0);
        check_eq("rx01_ferr", n_ferr, 0);
        check_eq("rx01_pulse_cycle", first_idx, 169);
        check_eq("rx01_data", 32'(data_out), 32'h01);

        // RX: back-to-back 0xA5 then 0x80
        rx_run({1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 22, 16, 24);
        check_eq("rxb2b_rdy", n_rdy, 2);
        check_eq("rxb2b_err", n_perr + n_ferr, 0);
        check_eq("rxb2b_first", first_idx, 169);
        check_eq("rxb2b_last", last_idx, 345);
        check_eq("rxb2b_data", 32'(data_out), 32'h80);

        // RX: 4-cycle start glitch
        rx_run(22'h0, 1, 4, 40);
        check_eq("glitch_pulses", n_rdy + n_perr + n_ferr, 0);
        check_eq("glitch_data", 32'(data_out), 32'h80);
        check_eq("glitch_state", 32'(rx_state_dbg), 32'(RX_IDLE));

        // RX: break of 20 bit times
        rx_run(22'h0, 20, 16, 40);
        check_eq("break_ferr", n_ferr, 1);
        check_eq("break_rdy", n_rdy, 0);
        check_eq("break_perr", n_perr, 0);
        check_eq("break_pulse_cycle", first_idx, 169);
        check_eq("break_data", 32'(data_out), 0);

        // RX: recovery after break
        rx_run({11'h0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 16, 24);
        check_eq("rx5a_rdy", n_rdy, 1);
        check_eq("rx5a_err", n_perr + n_ferr, 0);
        check_eq("rx5a_data", 32'(data_out), 32'h5A);

        // TX: 0xA5
        run_tx(8'hA5, -1);
        // TX: 0x3C with an ignored request at frame cycle 50
        run_tx(8'h3C, 50);

        // TX: reset during data bit 3, then a fresh 0x5A frame
        start_transmission = 1'b1;
        data_in            = 8'hFF;
        @(negedge clk);
        start_transmission = 1'b0;
        repeat (72) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx), 1);
        check_eq("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("postrst_tx", 32'(tx), 1);
        run_tx(8'h5A, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
